// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage and MEM/WB register against a req/ready data memory.
// Define MEM_ALIGN_CHECK_EN to trap misaligned word/half accesses and add MisalignOut.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = 7
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        EX_MEM_ValidIn,
  input  logic [31:0] EX_MEM_ALUResultIn,
  input  logic [31:0] EX_MEM_WriteDataIn,
  input  logic        EX_MEM_MemReadIn,
  input  logic        EX_MEM_MemWriteIn,
  input  logic [1:0]  EX_MEM_SizeIn,
  input  logic        EX_MEM_UnsignedIn,
  input  logic        EX_MEM_MemtoRegIn,
  input  logic        EX_MEM_RegWriteIn,
  input  logic [4:0]  EX_MEM_WriteRegIn,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [31:0] DMemWData,
  output logic [3:0]  DMemByteEn,
  input  logic [31:0] DMemRData,
  input  logic        DMemReady,
  output logic        MemStall,
  output logic        MemTimeout,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        MisalignOut,
`endif
  output logic [31:0] MEM_WB_LoadMuxOut,
  output logic [31:0] MEM_WB_ALUResultOut,
  output logic        MEM_WB_MemtoRegOut,
  output logic        MEM_WB_RegWriteOut,
  output logic [4:0]  MEM_WB_WriteRegOut
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic isMem, isHalf, isByte, misalign, access, abandon, complete, latch;
  logic [7:0] byteVal;
  logic [15:0] halfVal;
  logic [31:0] loadData;
  assign isMem = EX_MEM_ValidIn & (EX_MEM_MemReadIn | EX_MEM_MemWriteIn);
  assign isHalf = EX_MEM_SizeIn == 2'b01;
  assign isByte = EX_MEM_SizeIn == 2'b10;
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = isMem & ((~isHalf & ~isByte & |EX_MEM_ALUResultIn[1:0]) | (isHalf & EX_MEM_ALUResultIn[0]));
`else
  assign misalign = 1'b0;
`endif
  assign access = isMem & ~misalign;
  assign abandon = (state == WAIT) & ~DMemReady & (cnt == CNT_W'(TIMEOUT_CYCLES));
  assign complete = access & DMemReady;
  // Non-memory instructions flow straight through; memory ones only on completion.
  assign latch = (EX_MEM_ValidIn & ~(EX_MEM_MemReadIn | EX_MEM_MemWriteIn)) | complete;
  assign DMemReq = access & ~Rst;
  assign DMemWe = access & EX_MEM_MemWriteIn & ~Rst;
  assign MemStall = access & ~DMemReady & ~abandon & ~Rst;
  assign DMemAddr = {EX_MEM_ALUResultIn[31:2], 2'b00};
  // Big-endian lanes: byte offset 0 lives in bits [31:24].
  assign DMemByteEn = isByte ? (4'b1000 >> EX_MEM_ALUResultIn[1:0]) :
                      isHalf ? (EX_MEM_ALUResultIn[1] ? 4'b0011 : 4'b1100) : 4'b1111;
  assign DMemWData = isByte ? {4{EX_MEM_WriteDataIn[7:0]}} :
                     isHalf ? {2{EX_MEM_WriteDataIn[15:0]}} : EX_MEM_WriteDataIn;
  assign byteVal = DMemRData[{~EX_MEM_ALUResultIn[1:0], 3'b000} +: 8];
  assign halfVal = EX_MEM_ALUResultIn[1] ? DMemRData[15:0] : DMemRData[31:16];
  assign loadData = isByte ? {{24{~EX_MEM_UnsignedIn & byteVal[7]}}, byteVal} :
                    isHalf ? {{16{~EX_MEM_UnsignedIn & halfVal[15]}}, halfVal} : DMemRData;
  always_comb begin
    stateNext = state;
    cntNext = cnt;
    stateNext = (state == IDLE) ? ((access & ~DMemReady) ? WAIT : IDLE) :
                ((~access | DMemReady | abandon) ? IDLE : WAIT);
    cntNext = (stateNext == WAIT) ? ((state == IDLE) ? CNT_W'(1) : cnt + 1'b1) : '0;
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      cnt <= '0;
      MemTimeout <= 1'b0;
      MEM_WB_LoadMuxOut <= '0;
      MEM_WB_ALUResultOut <= '0;
      MEM_WB_MemtoRegOut <= 1'b0;
      MEM_WB_RegWriteOut <= 1'b0;
      MEM_WB_WriteRegOut <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      MisalignOut <= 1'b0;
`endif
    end else begin
      state <= stateNext;
      cnt <= cntNext;
      if (abandon) MemTimeout <= 1'b1;
      MEM_WB_RegWriteOut <= latch & EX_MEM_RegWriteIn;
      MEM_WB_MemtoRegOut <= latch & EX_MEM_MemtoRegIn;
      if (latch) begin
        MEM_WB_LoadMuxOut <= loadData;
        MEM_WB_ALUResultOut <= EX_MEM_ALUResultIn;
        MEM_WB_WriteRegOut <= EX_MEM_WriteRegIn;
      end
`ifdef MEM_ALIGN_CHECK_EN
      MisalignOut <= misalign;
`endif
    end
  end
endmodule
